pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised elastic pipeline register between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Carries NCH data channels of WIDTH bits each, plus a valid bit.
//  - Uses a ready/valid handshake with a 2-entry skid buffer, so in_ready is never
//    combinationally dependent on out_ready.
//  - Supports freeze (hazard stall) and flush (branch squash).
// PARAMETERS
//  WIDTH   32  bits per channel
//  NCH     2   number of channels; packed bus width = NCH*WIDTH, channel k = [k*WIDTH +: WIDTH]
//  CNT_W   16  width of statistics counters (used only with PIPE_STATS_EN)
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            asynchronous reset, active-high
//  freeze       in   1            hold stage: no push, no pop
//  flush        in   1            discard all held entries (synchronous)
//  in_valid     in   1            upstream data valid
//  in_ready     out  1            stage can accept
//  in_data      in   NCH*WIDTH    upstream data
//  out_valid    out  1            stage holds valid data
//  out_ready    in   1            downstream accepts
//  out_data     out  NCH*WIDTH    head entry
//  stall_cnt    out  CNT_W        [PIPE_STATS_EN only] cycles with out_valid & ~pop
//  squash_cnt   out  CNT_W        [PIPE_STATS_EN only] valid entries discarded by flush
// BEHAVIOUR
//  - Storage: main reg (head, drives out_data) and skid reg. State held as EMPTY / ONE / TWO.
//  - Reset (async, rst=1): state=EMPTY, main=0, skid=0, counters=0.
//    Outputs during reset: out_valid=0, out_data=0, in_ready=0.
//  - Derived signals:
//    - out_valid = (state != EMPTY)
//    - in_ready  = ~freeze & ~flush & (state != TWO)   (freeze/flush gated combinationally)
//    - push = in_valid & in_ready
//    - pop  = out_valid & out_ready & ~freeze & ~flush
//  - Transitions on the clk edge (flush has priority over everything):
//    - flush: state->EMPTY, main<=0, skid<=0; in_data is dropped.
//    - EMPTY: push -> ONE, main<=in_data.
//    - ONE: push&pop -> ONE, main<=in_data.
//           push only -> TWO, skid<=in_data.
//           pop only -> EMPTY, main<=0.
//    - TWO: pop -> ONE, main<=skid. Push is impossible (in_ready=0).
//    - No push and no pop: hold. Freeze is always a hold.
//  - Latency: 1 cycle in->out. Throughput: 1 transfer/cycle with out_ready held high.
//  - Ordering: strict FIFO. out_data stays stable while out_valid & ~pop.
//  - Reset asserted mid-transfer: both entries are lost and no partial state remains.
//  - Width rules: no arithmetic on data; channels pass bit-exact; NCH=1 is legal.
// CONFIGURATION
//  - PIPE_STATS_EN defined:
//    - stall_cnt +1 per cycle with out_valid=1 & pop=0.
//    - squash_cnt +1 per flush cycle, by popcount of held entries (0, 1 or 2).
//    - Both counters saturate at 2^CNT_W-1 and clear only on rst.
//  - PIPE_STATS_EN undefined: counters and both ports are absent; datapath timing is identical.
// TESTING
//  1. Streaming: NCH=2, WIDTH=32, out_ready=1; push A0..A9 (A_i={i,~i}) back-to-back
//     -> out_valid from cycle 1, A0..A9 on consecutive cycles, in_ready stays 1.
//  2. Backpressure: out_ready=0, push 0x11, 0x22, offer 0x33
//     -> state TWO, in_ready=0, 0x33 not taken.
//     Then out_ready=1 -> outputs 0x11, 0x22, 0x33 in order, no loss or duplication.
//  3. Freeze: state ONE holding 0x55, freeze=1 for 3 cycles with in_valid=1, out_ready=1
//     -> in_ready=0, out_data=0x55 for all 3 cycles. Release -> 0x55 pops.
//  4. Flush: state TWO, flush=1 for 1 cycle together with in_valid=1
//     -> next cycle out_valid=0, out_data=0, input dropped.
//     With PIPE_STATS_EN: squash_cnt=2.
//  5. Async reset: assert rst mid-cycle while in TWO
//     -> out_valid=0, out_data=0 immediately (no clk edge). After release, first push is
//     delivered normally.
//  6. Stats saturation: CNT_W=4, PIPE_STATS_EN, hold out_valid=1 & out_ready=0 for 20 cycles
//     -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Ready/valid bundle for pipe_stage_reg: upstream push side plus downstream pop side.
// master = the environment driving the stage, slave = the stage itself.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic two-entry pipeline register with freeze/flush between CPU stages.
// Optional statistics counters are enabled by defining PIPE_STATS_EN.
module pipe_stage_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic freeze,
  input  logic flush,
  pipe_stage_reg_if.slave bus
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
`endif
);

  localparam int unsigned DW = NCH * WIDTH;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   main_q, skid_q;
  logic            push, pop;
  logic            main_from_in, main_from_skid, main_clr, skid_from_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= EMPTY;
    else if (flush) state <= EMPTY;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (!push && pop) state_nxt = EMPTY;
      end
      TWO:   if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready is gated by rst so nothing looks acceptable while reset is held.
  always_comb begin
    bus.out_valid  = (state != EMPTY);
    bus.in_ready   = !rst && !freeze && !flush && (state != TWO);
    bus.out_data   = main_q;
    push           = bus.in_valid && bus.in_ready;
    pop            = bus.out_valid && bus.out_ready && !freeze && !flush;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_from_in   = 1'b0;
    unique case (state)
      EMPTY: main_from_in = push;
      ONE: begin
        main_from_in = push && pop;
        skid_from_in = push && !pop;
        main_clr     = !push && pop;
      end
      TWO:   main_from_skid = pop;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_from_in)        main_q <= bus.in_data;
      else if (main_from_skid) main_q <= skid_q;
      else if (main_clr)       main_q <= '0;
      if (skid_from_in)        skid_q <= bus.in_data;
    end
  end

`ifdef PIPE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]     held;
  logic [CNT_W:0] squash_sum;

  always_comb begin
    held = 2'd0;
    unique case (state)
      ONE:     held = 2'd1;
      TWO:     held = 2'd2;
      default: held = 2'd0;
    endcase
    squash_sum = {1'b0, squash_cnt} + {{(CNT_W-1){1'b0}}, held};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (bus.out_valid && !pop && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush)
        squash_cnt <= squash_sum[CNT_W] ? CNT_MAX : squash_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: driver feeds a scoreboard queue on each accepted
// push, an independent monitor pops and compares on each downstream transfer.
module tb_pipe_stage_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NCH   = 2;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic freeze = 1'b0;
  logic flush  = 1'b0;

  pipe_stage_reg_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt, squash_cnt;
`endif

  pipe_stage_reg #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .freeze (freeze),
    .flush  (flush),
    .bus    (bus)
`ifdef PIPE_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .squash_cnt (squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  logic        hs_s, fl_s;
  logic [63:0] d_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // First half of a cycle: wait for the falling edge and capture the handshake.
  task automatic cb();
    @(negedge clk);
    hs_s = bus.in_valid && bus.in_ready && !rst;
    fl_s = flush;
    d_s  = bus.in_data;
  endtask

  // Second half: cross the rising edge, then update the model like the stage would.
  task automatic ce();
    @(posedge clk);
    #1;
    if (fl_s) sb.delete();
    if (hs_s) sb.push_back(d_s);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready && !freeze && !flush) begin
      if (sb.size() == 0) check("pop_unexpected", 64'd1, 64'd0);
      else                check("out_data_pop", bus.out_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data",  bus.out_data, 64'd0);
    check("rst_in_ready",  {63'd0, bus.in_ready}, 64'd0);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    // Streaming: A_i = {i, ~i}, one per cycle.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {32'(i), ~32'(i)};
      cb();
      check("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
      if (i > 0) check("stream_out_valid", {63'd0, bus.out_valid}, 64'd1);
      ce();
    end
    bus.in_valid = 1'b0;
    cb(); ce();
    cb(); check("stream_drained", {63'd0, bus.out_valid}, 64'd0); ce();

    // Backpressure into TWO, then release.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'h11; cb(); ce();
    bus.in_data   = 64'h22; cb(); ce();
    bus.in_data   = 64'h33;
    cb();
    check("bp_in_ready",  {63'd0, bus.in_ready}, 64'd0);
    check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("bp_head",      bus.out_data, 64'h11);
    ce();
    cb(); check("bp_still_full", {63'd0, bus.in_ready}, 64'd0); ce();
    bus.out_ready = 1'b1;
    cb(); ce();
    cb(); ce();
    bus.in_valid = 1'b0;
    cb(); ce();
    cb(); check("bp_drained", {63'd0, bus.out_valid}, 64'd0); ce();

    // Freeze holding 0x55.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'h55;
    cb(); ce();
    freeze = 1'b1;
    bus.in_data   = 64'h66;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cb();
      check("frz_in_ready",  {63'd0, bus.in_ready}, 64'd0);
      check("frz_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("frz_out_data",  bus.out_data, 64'h55);
      ce();
    end
    freeze = 1'b0;
    bus.in_valid = 1'b0;
    cb(); check("frz_release", bus.out_data, 64'h55); ce();
    cb(); check("frz_drained", {63'd0, bus.out_valid}, 64'd0); ce();

    // Flush from TWO with a concurrent offer.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hA1; cb(); ce();
    bus.in_data   = 64'hA2; cb(); ce();
    flush = 1'b1;
    bus.in_data   = 64'hA3;
    cb(); check("fl_in_ready", {63'd0, bus.in_ready}, 64'd0); ce();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    cb();
    check("fl_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("fl_out_data",  bus.out_data, 64'd0);
`ifdef PIPE_STATS_EN
    check("fl_squash_cnt", 64'(squash_cnt), 64'd2);
`endif
    ce();

    // Asynchronous reset while TWO.
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hB1; cb(); ce();
    bus.in_data  = 64'hB2; cb(); ce();
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("arst_out_data",  bus.out_data, 64'd0);
    check("arst_in_ready",  {63'd0, bus.in_ready}, 64'd0);
    sb.delete();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
`ifdef PIPE_STATS_EN
    check("arst_stall_cnt",  64'(stall_cnt), 64'd0);
    check("arst_squash_cnt", 64'(squash_cnt), 64'd0);
`endif
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hC1;
    cb(); ce();
    bus.in_valid = 1'b0;
    cb(); check("arst_first_push", bus.out_data, 64'hC1); ce();
    cb(); check("arst_drained", {63'd0, bus.out_valid}, 64'd0); ce();

    // Long stall: stall counter saturates at 15 with CNT_W=4.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hD1;
    cb(); ce();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cb(); ce();
    end
    cb();
    check("stall_hold_data", bus.out_data, 64'hD1);
`ifdef PIPE_STATS_EN
    check("stall_cnt_sat", 64'(stall_cnt), 64'd15);
`endif
    ce();
    bus.out_ready = 1'b1;
    cb(); ce();
    cb(); check("final_out_valid", {63'd0, bus.out_valid}, 64'd0); ce();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
